// File: rtl/bht_assoc.sv
// Fully-associative branch target buffer: combinational lookup for the fetch PC+4,
// registered update from execute, true-LRU replacement and saturating statistics.
module bht_assoc #(
  parameter int ADDR_WIDTH       = 10,
  parameter int ENTRIES          = 8,
  parameter int CNT_WIDTH        = 16,
  parameter int ALLOC_TAKEN_ONLY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] lookup_pc4,
  output logic [ADDR_WIDTH-1:0] pred_pc,
  output logic [1:0]            pred_state,
  output logic                  pred_hit,
  input  logic                  update_en,
  input  logic [ADDR_WIDTH-1:0] update_pc4,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic [1:0]            update_state_old,
  input  logic                  update_taken,
  output logic [CNT_WIDTH-1:0]  stat_updates,
  output logic [CNT_WIDTH-1:0]  stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic                  valid  [ENTRIES];
  logic [ADDR_WIDTH-1:0] tag    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target [ENTRIES];
  logic [1:0]            state  [ENTRIES];
  logic [IDX_W-1:0]      age    [ENTRIES];

  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic             up_hit;
  logic [IDX_W-1:0] up_idx;
  logic             found_inv;
  logic [IDX_W-1:0] victim_idx;
  logic             do_alloc;
  logic             touch;
  logic [IDX_W-1:0] touch_idx;
  logic [IDX_W-1:0] touch_age;

  // Encoding 01 strong-NT, 00 weak-NT, 10 weak-T, 11 strong-T.
  function automatic logic [1:0] next_ctr(input logic [1:0] s, input logic t);
    case (s)
      2'b01:   return t ? 2'b00 : 2'b01;
      2'b00:   return t ? 2'b10 : 2'b01;
      2'b10:   return t ? 2'b11 : 2'b00;
      default: return t ? 2'b11 : 2'b10;
    endcase
  endfunction

  always_comb begin
    lk_hit = 1'b0;
    lk_idx = '0;
    up_hit = 1'b0;
    up_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == lookup_pc4) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid[i] && tag[i] == update_pc4) begin
        up_hit = 1'b1;
        up_idx = IDX_W'(i);
      end
    end
  end

  assign pred_hit   = lk_hit;
  assign pred_state = lk_hit ? state[lk_idx] : 2'b00;
  assign pred_pc    = (lk_hit && state[lk_idx][1]) ? target[lk_idx] : lookup_pc4;

  // Lowest-index invalid entry first; only a full table falls back to the oldest entry.
  always_comb begin
    found_inv  = 1'b0;
    victim_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        found_inv  = 1'b1;
        victim_idx = IDX_W'(i);
      end
    end
    if (!found_inv) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (age[i] == IDX_W'(ENTRIES - 1)) victim_idx = IDX_W'(i);
      end
    end
  end

  assign do_alloc  = !up_hit && ((ALLOC_TAKEN_ONLY == 0) || update_taken);
  assign touch     = update_en && !flush && (up_hit || do_alloc);
  assign touch_idx = up_hit ? up_idx : victim_idx;
  assign touch_age = age[touch_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        state[i]  <= 2'b00;
        age[i]    <= IDX_W'(i);
      end
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
      end else if (update_en) begin
        if (up_hit) begin
          target[up_idx] <= update_target;
          state[up_idx]  <= next_ctr(update_state_old, update_taken);
        end else if (do_alloc) begin
          valid[victim_idx]  <= 1'b1;
          tag[victim_idx]    <= update_pc4;
          target[victim_idx] <= update_target;
          state[victim_idx]  <= next_ctr(2'b00, update_taken);
        end
      end
      if (touch) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (IDX_W'(i) == touch_idx)  age[i] <= '0;
          else if (age[i] < touch_age) age[i] <= age[i] + IDX_W'(1);
        end
      end
      // Statistics count every strobe, even one swallowed by a flush.
      if (update_en) begin
        if (stat_updates != '1) stat_updates <= stat_updates + CNT_WIDTH'(1);
        if ((update_state_old[1] != update_taken) && (stat_mispredicts != '1))
          stat_mispredicts <= stat_mispredicts + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bht_assoc.sv
// Directed bench for bht_assoc: a default instance plus a CNT_WIDTH=4 instance
// sharing the same stimulus so counter saturation is reachable quickly.
module tb_bht_assoc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [9:0] lookup_pc4 = '0;
  logic       update_en = 1'b0;
  logic [9:0] update_pc4 = '0;
  logic [9:0] update_target = '0;
  logic [1:0] update_state_old = '0;
  logic       update_taken = 1'b0;

  logic [9:0]  pred_pc;
  logic [1:0]  pred_state;
  logic        pred_hit;
  logic [15:0] stat_updates;
  logic [15:0] stat_mispredicts;

  logic [9:0] pred_pc_s;
  logic [1:0] pred_state_s;
  logic       pred_hit_s;
  logic [3:0] stat_updates_s;
  logic [3:0] stat_mispredicts_s;

  int checks = 0;
  int errors = 0;
  int exp_upd = 0;
  int exp_mis = 0;

  always #5 clk = ~clk;

  bht_assoc u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .lookup_pc4(lookup_pc4),
    .pred_pc(pred_pc), .pred_state(pred_state), .pred_hit(pred_hit),
    .update_en(update_en), .update_pc4(update_pc4), .update_target(update_target),
    .update_state_old(update_state_old), .update_taken(update_taken),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  bht_assoc #(.CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush), .lookup_pc4(lookup_pc4),
    .pred_pc(pred_pc_s), .pred_state(pred_state_s), .pred_hit(pred_hit_s),
    .update_en(update_en), .update_pc4(update_pc4), .update_target(update_target),
    .update_state_old(update_state_old), .update_taken(update_taken),
    .stat_updates(stat_updates_s), .stat_mispredicts(stat_mispredicts_s)
  );

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // One update (and/or flush) beat; the expected statistics track every strobe.
  task automatic applyStimulus(input logic en, input logic [9:0] pc4, input logic [9:0] tgt,
                               input logic [1:0] st_old, input logic taken, input logic fl);
    @(negedge clk);
    update_en        = en;
    update_pc4       = pc4;
    update_target    = tgt;
    update_state_old = st_old;
    update_taken     = taken;
    flush            = fl;
    @(posedge clk);
    #1;
    update_en = 1'b0;
    flush     = 1'b0;
    if (en) begin
      exp_upd++;
      if (st_old[1] != taken) exp_mis++;
    end
  endtask

  task automatic checkLookup(input string name, input logic [9:0] pc, input logic exp_hit,
                             input logic [1:0] exp_state, input logic [9:0] exp_pc);
    lookup_pc4 = pc;
    #1;
    checkOutput({name, ".hit"}, 32'(pred_hit), 32'(exp_hit));
    checkOutput({name, ".state"}, 32'(pred_state), 32'(exp_state));
    checkOutput({name, ".pc"}, 32'(pred_pc), 32'(exp_pc));
  endtask

  task automatic checkStats(input string name);
    checkOutput({name, ".upd"}, 32'(stat_updates), 32'(exp_upd));
    checkOutput({name, ".mis"}, 32'(stat_mispredicts), 32'(exp_mis));
  endtask

  initial begin
    #12;
    checkLookup("reset", 10'h004, 1'b0, 2'b00, 10'h004);
    checkLookup("reset_tag0", 10'h000, 1'b0, 2'b00, 10'h000);
    checkStats("reset");
    checkOutput("reset_sat_hit", 32'(pred_hit_s), 32'd0);
    checkOutput("reset_sat_state", 32'(pred_state_s), 32'd0);
    checkOutput("reset_sat_pc", 32'(pred_pc_s), 32'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // Allocate, then retrain the same entry toward not-taken.
    lookup_pc4 = 10'h010;
    applyStimulus(1'b1, 10'h010, 10'h080, 2'b00, 1'b1, 1'b0);
    checkLookup("alloc", 10'h010, 1'b1, 2'b10, 10'h080);
    applyStimulus(1'b1, 10'h010, 10'h080, 2'b10, 1'b0, 1'b0);
    checkLookup("retrain", 10'h010, 1'b1, 2'b00, 10'h010);
    checkStats("retrain");

    applyStimulus(1'b1, 10'h020, 10'h0A0, 2'b00, 1'b0, 1'b0);
    checkLookup("nt_noalloc", 10'h020, 1'b0, 2'b00, 10'h020);
    checkStats("nt_noalloc");

    // Fill: 0x100..0x118 take entries 1..7, 0x11C evicts 0x010 in entry 0.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 10'(10'h100 + 4 * i), 10'(10'h200 + 4 * i), 2'b00, 1'b1, 1'b0);
    checkLookup("evict_010", 10'h010, 1'b0, 2'b00, 10'h010);
    checkLookup("fill_11C", 10'h11C, 1'b1, 2'b10, 10'h21C);
    applyStimulus(1'b1, 10'h100, 10'h3F0, 2'b10, 1'b1, 1'b0);
    checkLookup("rehit_100", 10'h100, 1'b1, 2'b11, 10'h3F0);
    applyStimulus(1'b1, 10'h200, 10'h040, 2'b00, 1'b1, 1'b0);
    checkLookup("evict_104", 10'h104, 1'b0, 2'b00, 10'h104);
    checkLookup("keep_100", 10'h100, 1'b1, 2'b11, 10'h3F0);
    checkLookup("new_200", 10'h200, 1'b1, 2'b10, 10'h040);
    applyStimulus(1'b1, 10'h204, 10'h044, 2'b00, 1'b1, 1'b0);
    checkLookup("evict_108", 10'h108, 1'b0, 2'b00, 10'h108);
    checkLookup("keep_10C", 10'h10C, 1'b1, 2'b10, 10'h20C);
    checkLookup("new_204", 10'h204, 1'b1, 2'b10, 10'h044);
    checkStats("fill");

    // Flush beats a same-cycle update, but the statistics still count it.
    applyStimulus(1'b1, 10'h300, 10'h0F0, 2'b00, 1'b1, 1'b1);
    checkLookup("flush_300", 10'h300, 1'b0, 2'b00, 10'h300);
    checkLookup("flush_100", 10'h100, 1'b0, 2'b00, 10'h100);
    checkLookup("flush_204", 10'h204, 1'b0, 2'b00, 10'h204);
    checkStats("flush");
    applyStimulus(1'b1, 10'h300, 10'h0F0, 2'b00, 1'b1, 1'b0);
    checkLookup("post_flush", 10'h300, 1'b1, 2'b10, 10'h0F0);

    for (int i = 0; i < 19; i++)
      applyStimulus(1'b1, 10'h050, 10'h060, 2'b00, 1'b1, 1'b0);
    checkOutput("sat_upd", 32'(stat_updates_s), 32'hF);
    checkOutput("sat_mis", 32'(stat_mispredicts_s), 32'hF);
    checkStats("wide_stats");

    // Asynchronous reset away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkLookup("async_rst", 10'h300, 1'b0, 2'b00, 10'h300);
    checkOutput("async_rst.upd", 32'(stat_updates), 32'd0);
    checkOutput("async_rst.mis", 32'(stat_mispredicts), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bht_assoc.md
# bht_assoc

Parametrised fully-associative branch target buffer with per-entry valid bits, true-LRU replacement, 2-bit direction counters, flush, and saturating statistics counters. It sits in the fetch stage beside the PC mux. The combinational lookup port supplies the next-PC guess for the current fetch PC+4. The registered update port is driven from execute when a branch resolves.

## Interface
- ADDR_WIDTH, 10: width of PC+4 and target addresses.
- ENTRIES, 8: table depth; power of two, ≥2.
- CNT_WIDTH, 16: width of each statistics counter.
- ALLOC_TAKEN_ONLY, 1: 1 = allocate on a miss only if the branch was taken; 0 = always allocate.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  invalidate all entries; synchronous.
- lookup_pc4  in  ADDR_WIDTH  PC+4 of the instruction being fetched.
- pred_pc  out  ADDR_WIDTH  predicted next PC; combinational.
- pred_state  out  2  counter of the hit entry, 00 on miss; combinational.
- pred_hit  out  1  lookup hit a valid entry; combinational.
- update_en  in  1  resolved-branch update strobe.
- update_pc4  in  ADDR_WIDTH  PC+4 of the resolved branch.
- update_target  in  ADDR_WIDTH  resolved taken target.
- update_state_old  in  2  pred_state carried down the pipe with the branch.
- update_taken  in  1  actual branch outcome.
- stat_updates  out  CNT_WIDTH  count of accepted updates.
- stat_mispredicts  out  CNT_WIDTH  count of direction mispredicts.

## Operation
- Entry fields: valid, tag (ADDR_WIDTH), target (ADDR_WIDTH), state (2), age (log2 ENTRIES).
- Counter encoding: 01 strong-NT, 00 weak-NT, 10 weak-T, 11 strong-T. Predict taken iff state[1].
- Counter on taken: 01→00, 00→10, 10→11, 11→11.
- Counter on not-taken: 11→10, 10→00, 00→01, 01→01.
- Lookup: hit iff some valid entry has tag == lookup_pc4.
  - pred_pc = target if hit and state[1], else lookup_pc4.
  - Tags are unique, so a hit selects exactly one entry.
- Update hit (valid tag == update_pc4):
  - Rewrite target := update_target.
  - state := next(update_state_old, update_taken).
- Update miss:
  - If ALLOC_TAKEN_ONLY and !update_taken: the table is unchanged and LRU is untouched.
  - Otherwise write a victim: valid=1, tag, target, state := next(00, update_taken).
  - Victim is the lowest-index invalid entry. If every entry is valid, the victim is the entry with age == ENTRIES-1.
- LRU: ages always form a permutation of 0..ENTRIES-1.
  - A touch happens on an update hit or an allocation.
  - On a touch, every entry whose age is less than the touched entry's age increments; the touched entry becomes 0.
  - Lookups never touch.
- Statistics: every update_en increments stat_updates. stat_mispredicts increments when update_en and update_state_old[1] != update_taken. Both saturate at all-ones.
- Flush clears all valid bits only. Ages, contents and statistics are retained.

## Timing
- Reset values:
  - valid=0, tag=0, target=0, state=00, age[i]=i, both statistics=0.
  - Outputs: pred_hit=0, pred_state=00, pred_pc=lookup_pc4.
- Lookup is zero-latency combinational from registered table state.
- Updates take effect at the next posedge clk. A lookup in the same cycle sees the pre-update table, so there is no bypass.
- Same-cycle flush and update_en:
  - Flush wins; no entry is written and the LRU is unchanged.
  - Statistics still count the update.
- Duplicate tags are impossible, because allocation happens only on a miss.
- rst_n asserted mid-operation returns every register to its reset value immediately, with no clock required.

## Test plan
- After reset, lookup_pc4=0x004 → pred_hit=0, pred_pc=0x004, pred_state=00. Note that tag 0 must not match, because valid=0.
- Update pc4=0x010, target=0x080, state_old=00, taken=1 → next cycle lookup 0x010 gives hit=1, state=10, pred_pc=0x080. Then update with state_old=10, taken=0 → state=00, pred_pc=0x010.
- With ALLOC_TAKEN_ONLY=1, update pc4=0x020, taken=0 → lookup 0x020 misses. stat_updates increments; stat_mispredicts is unchanged.
- Fill 8 entries with pc4 0x100..0x11C step 4, re-update 0x100, then allocate 0x200 → 0x104 is evicted and 0x100 still hits. A second allocation, 0x204, evicts 0x108.
- Flush on the same cycle as update_en for 0x300 → all lookups miss, 0x300 is not present, and stat_updates increments.
- Drive 2^CNT_WIDTH+3 mispredicting updates with CNT_WIDTH=4 → both counters hold 0xF.
